// File: rtl/raycast_pkg.sv
// ---------------------------------------------------------------------------
// raycast_pkg
// Shared definitions for the octree node fetch unit:
//   - fetch FSM state encoding
//   - Wishbone byte-select constant
//   - address / data widths
//   - word alignment helper
// ---------------------------------------------------------------------------
package raycast_pkg;

   localparam int ADR_W = 32;
   localparam int DATA_W = 32;

   localparam logic [3:0] WB_SEL_ALL = 4'hF;

   localparam logic [ADR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_BUS,
      ST_RESP,
      ST_GAP
   } state_e;

   // Force a byte address onto a 32-bit word boundary.
   function automatic logic [ADR_W-1:0] word_align(input logic [ADR_W-1:0] a);
      return a & WORD_MASK;
   endfunction

endpackage

// File: rtl/raycast_node_cache.sv
// ---------------------------------------------------------------------------
// raycast_node_cache
// Direct-mapped, one-word-per-line node cache (valid / tag / data arrays).
//
// Ports:
//   clk          system clock
//   rst_ni       asynchronous active-low reset (clears valid bits)
//   flush_i      invalidate every line at the next edge; beats a write
//   rd_idx_i     read index, sampled at the edge
//   rd_valid_o   registered valid bit of the line read
//   rd_tag_o     registered tag of the line read
//   rd_data_o    registered data word of the line read
//   wr_en_i      write one line (valid=1, tag, data)
//   wr_idx_i     write index
//   wr_tag_i     write tag
//   wr_data_i    write data
// ---------------------------------------------------------------------------
module raycast_node_cache
   import raycast_pkg::*;
#(
   parameter int LINES = 16,
   localparam int IDX_W = $clog2(LINES),
   localparam int TAG_W = ADR_W - IDX_W - 2
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   logic [LINES-1:0]  valid_q;
   logic              rd_valid_q;
   logic [TAG_W-1:0]  rd_tag_q;
   logic [DATA_W-1:0] rd_data_q;

   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];

   // A read to the line being written in the same cycle returns the new
   // contents, so a far pointer resolved straight from a fill sees the fill.
   logic wr_hits_rd;
   assign wr_hits_rd = wr_en_i && (wr_idx_i == rd_idx_i);

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         // A flush in the read cycle must also hide the line being read.
         rd_valid_q <= !flush_i && (wr_hits_rd || valid_q[rd_idx_i]);
         if (flush_i) begin
            valid_q <= '0;
         end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
         end
      end
   end

   // Tag/data storage carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_mem[wr_idx_i]  <= wr_tag_i;
         data_mem[wr_idx_i] <= wr_data_i;
      end
      if (wr_hits_rd) begin
         rd_tag_q  <= wr_tag_i;
         rd_data_q <= wr_data_i;
      end else begin
         rd_tag_q  <= tag_mem[rd_idx_i];
         rd_data_q <= data_mem[rd_idx_i];
      end
   end

   assign rd_valid_o = rd_valid_q;
   assign rd_tag_o   = rd_tag_q;
   assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/raycast_node_fetch.sv
// ---------------------------------------------------------------------------
// raycast_node_fetch
// Serves octree node reads for raycast_core. Looks words up in a small
// direct-mapped cache, fetches misses over a read-only Wishbone classic
// master, and resolves far pointers by reading the pointer word first.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-low reset
//   node_req_i      request level, held until node_ack_o
//   node_req_far_i  request address holds a far pointer
//   node_req_adr_i  byte address of requested word
//   node_ack_o      one-cycle response pulse
//   node_data_o     returned node word (held until next response)
//   node_adr_o      address the word came from, after far resolution
//   flush_i         invalidate all cache lines
//   wb_cyc_o/wb_stb_o/wb_adr_o/wb_sel_o/wb_we_o   Wishbone master outputs
//   wb_dat_i/wb_ack_i/wb_err_i                    Wishbone master inputs
// ---------------------------------------------------------------------------
module raycast_node_fetch
   import raycast_pkg::*;
#(
   parameter int CACHE_LINES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              node_req_i,
   input  logic              node_req_far_i,
   input  logic [ADR_W-1:0]  node_req_adr_i,
   output logic              node_ack_o,
   output logic [DATA_W-1:0] node_data_o,
   output logic [ADR_W-1:0]  node_adr_o,
   input  logic              flush_i,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic [ADR_W-1:0]  wb_adr_o,
   output logic [3:0]        wb_sel_o,
   output logic              wb_we_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i
);

   localparam int IDX_W = $clog2(CACHE_LINES);
   localparam int TAG_W = ADR_W - IDX_W - 2;

   state_e            state_q, state_d;
   logic [ADR_W-1:0]  adr_q, adr_d;
   logic              far_q, far_d;
   logic              done_q;
   logic [DATA_W-1:0] bdat_q;
   logic              berr_q;
   logic              flush_pend_q, flush_pend_d;
   logic              cyc_q, cyc_d;
   logic [ADR_W-1:0]  wb_adr_q, wb_adr_d;
   logic              ack_q;
   logic [DATA_W-1:0] ndata_q;
   logic [ADR_W-1:0]  nadr_q;

   logic              bus_resp;
   logic              resp_set;
   logic [DATA_W-1:0] resp_data;
   logic              fill_we;
   logic              hit;

   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [DATA_W-1:0] rd_data;

   // Read index follows the next working address so the registered read
   // lands exactly when LOOKUP evaluates it.
   raycast_node_cache #(
      .LINES (CACHE_LINES)
   ) u_cache (
      .clk        (clk),
      .rst_ni     (rst),
      .flush_i    (flush_i),
      .rd_idx_i   (adr_d[IDX_W+1:2]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (fill_we),
      .wr_idx_i   (adr_q[IDX_W+1:2]),
      .wr_tag_i   (adr_q[ADR_W-1:IDX_W+2]),
      .wr_data_i  (bdat_q)
   );

   assign hit      = rd_valid && (rd_tag == adr_q[ADR_W-1:IDX_W+2]);
   // Only responses to our own open cycle count.
   assign bus_resp = cyc_q && (wb_ack_i || wb_err_i);

   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      far_d     = far_q;
      resp_set  = 1'b0;
      resp_data = '0;
      fill_we   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (node_req_i) begin
               adr_d   = word_align(node_req_adr_i);
               far_d   = node_req_far_i;
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (hit) begin
               if (far_q) begin
                  adr_d = word_align(rd_data);
                  far_d = 1'b0;
               end else begin
                  resp_set  = 1'b1;
                  resp_data = rd_data;
                  state_d   = ST_RESP;
               end
            end else begin
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            // Bus response is registered first (done_q) and acted on in the
            // following cycle, with cyc/stb already dropped.
            if (done_q) begin
               if (berr_q) begin
                  far_d     = 1'b0;
                  resp_set  = 1'b1;
                  resp_data = '0;
                  state_d   = ST_RESP;
               end else begin
                  fill_we = !flush_pend_q;
                  if (far_q) begin
                     adr_d   = word_align(bdat_q);
                     far_d   = 1'b0;
                     state_d = ST_LOOKUP;
                  end else begin
                     resp_set  = 1'b1;
                     resp_data = bdat_q;
                     state_d   = ST_RESP;
                  end
               end
            end
         end
         ST_RESP: state_d = ST_GAP;
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // A flush seen anywhere during the bus cycle taints its data for filling.
      flush_pend_d = (state_q == ST_BUS) && (flush_pend_q || flush_i);
      cyc_d        = (state_d == ST_BUS) && !bus_resp && !done_q;
      wb_adr_d     = cyc_d ? adr_d : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         adr_q        <= '0;
         far_q        <= 1'b0;
         done_q       <= 1'b0;
         bdat_q       <= '0;
         berr_q       <= 1'b0;
         flush_pend_q <= 1'b0;
         cyc_q        <= 1'b0;
         wb_adr_q     <= '0;
         ack_q        <= 1'b0;
         ndata_q      <= '0;
         nadr_q       <= '0;
      end else begin
         state_q      <= state_d;
         adr_q        <= adr_d;
         far_q        <= far_d;
         done_q       <= bus_resp;
         flush_pend_q <= flush_pend_d;
         cyc_q        <= cyc_d;
         wb_adr_q     <= wb_adr_d;
         ack_q        <= resp_set;
         if (bus_resp) begin
            bdat_q <= wb_dat_i;
            berr_q <= wb_err_i;   // err wins over a simultaneous ack
         end
         if (resp_set) begin
            ndata_q <= resp_data;
            nadr_q  <= adr_q;
         end
      end
   end

   assign node_ack_o  = ack_q;
   assign node_data_o = ndata_q;
   assign node_adr_o  = nadr_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = cyc_q;
   assign wb_adr_o    = wb_adr_q;
   assign wb_sel_o    = WB_SEL_ALL;
   assign wb_we_o     = 1'b0;

endmodule

// File: tb/tb_raycast_node_fetch.sv
// ---------------------------------------------------------------------------
// tb_raycast_node_fetch
// Directed bench for raycast_node_fetch with a Wishbone memory model and a
// scoreboard of expected node responses.
// ---------------------------------------------------------------------------
module tb_raycast_node_fetch;

   localparam int BUS_LAT = 3;

   logic        clk;
   logic        rst_n;
   logic        node_req_i;
   logic        node_req_far_i;
   logic [31:0] node_req_adr_i;
   logic        node_ack_o;
   logic [31:0] node_data_o;
   logic [31:0] node_adr_o;
   logic        flush_i;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   typedef struct {
      logic [31:0] d;
      logic [31:0] a;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] bus_log[$];
   logic [31:0] mem[logic [31:0]];
   int          bus_reads = 0;
   int          checks = 0;
   int          errors = 0;
   logic        err_en = 1'b0;
   logic [31:0] err_adr = 32'h0;
   int          wait_cnt = 0;

   raycast_node_fetch #(
      .CACHE_LINES (16)
   ) dut (
      .clk            (clk),
      .rst            (rst_n),
      .node_req_i     (node_req_i),
      .node_req_far_i (node_req_far_i),
      .node_req_adr_i (node_req_adr_i),
      .node_ack_o     (node_ack_o),
      .node_data_o    (node_data_o),
      .node_adr_o     (node_adr_o),
      .flush_i        (flush_i),
      .wb_cyc_o       (wb_cyc_o),
      .wb_stb_o       (wb_stb_o),
      .wb_adr_o       (wb_adr_o),
      .wb_sel_o       (wb_sel_o),
      .wb_we_o        (wb_we_o),
      .wb_dat_i       (wb_dat_i),
      .wb_ack_i       (wb_ack_i),
      .wb_err_i       (wb_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Wishbone slave: responds BUS_LAT cycles after stb rises.
   initial begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         wb_dat_i = 32'h0;
         if (wb_cyc_o && wb_stb_o) begin
            wait_cnt++;
            if (wait_cnt == BUS_LAT + 1) begin
               wait_cnt = 0;
               bus_reads++;
               bus_log.push_back(wb_adr_o);
               check("wb_sel", {28'h0, wb_sel_o}, 32'hF);
               check("wb_adr_align", {30'h0, wb_adr_o[1:0]}, 32'h0);
               if (err_en && wb_adr_o == err_adr) begin
                  wb_err_i = 1'b1;
               end else begin
                  wb_ack_i = 1'b1;
                  wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : 32'h0;
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic flush_idle();
      @(posedge clk);
      #1 flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
   endtask

   // One request: push expectation, wait for ack, compare, check bus traffic.
   task automatic do_req(input logic [31:0] adr, input logic far,
                         input logic [31:0] exp_d, input logic [31:0] exp_a,
                         input int exp_bus, input int exp_lat, input logic flush_in_bus);
      exp_t e;
      exp_t got_e;
      int   n;
      int   last_resp;
      int   bus0;
      logic got;
      logic flushed;
      e.d = exp_d;
      e.a = exp_a;
      sb_q.push_back(e);
      bus0 = bus_reads;
      bus_log.delete();
      n = 0;
      last_resp = -100;
      got = 1'b0;
      flushed = 1'b0;
      @(posedge clk);
      #1;
      node_req_i     = 1'b1;
      node_req_far_i = far;
      node_req_adr_i = adr;
      while (!got && n < 200) begin
         @(negedge clk);
         flush_i = 1'b0;
         if (flush_in_bus && !flushed && wb_cyc_o) begin
            flush_i = 1'b1;
            flushed = 1'b1;
         end
         if (wb_ack_i || wb_err_i) last_resp = n;
         if (node_ack_o) begin
            got = 1'b1;
            node_req_i = 1'b0;
            if (sb_q.size() > 0) begin
               got_e = sb_q.pop_front();
               check("resp_data", node_data_o, got_e.d);
               check("resp_adr", node_adr_o, got_e.a);
            end else begin
               check("sb_nonempty", 32'h0, 32'h1);
            end
            check("bus_reads", bus_reads - bus0, exp_bus);
            if (exp_lat >= 0) check("ack_latency", n, exp_lat);
            if (exp_bus > 0) check("ack_after_bus", n - last_resp, 32'd2);
         end else begin
            n++;
         end
      end
      flush_i = 1'b0;
      if (!got) begin
         check("ack_timeout", 32'h0, 32'h1);
         node_req_i = 1'b0;
         sb_q.delete();
      end
      $display("req adr=0x%08h far=%0b -> data=0x%08h adr=0x%08h bus=%0d cycles=%0d",
               adr, far, node_data_o, node_adr_o, bus_reads - bus0, n);
      @(negedge clk);
      check("ack_pulse", {31'h0, node_ack_o}, 32'h0);
      check("data_hold", node_data_o, exp_d);
      @(posedge clk);
   endtask

   initial begin : main
      int n;
      rst_n          = 1'b0;
      node_req_i     = 1'b0;
      node_req_far_i = 1'b0;
      node_req_adr_i = 32'h0;
      flush_i        = 1'b0;
      mem[32'h100] = 32'hDEADBEEF;
      mem[32'h140] = 32'h0BADF00D;
      mem[32'h200] = 32'h00000403;
      mem[32'h400] = 32'h12345678;
      mem[32'h208] = 32'h0000040F;
      mem[32'h40C] = 32'h55AA33CC;
      mem[32'h300] = 32'hCAFEF00D;
      mem[32'h500] = 32'h600DCAFE;

      // 1: reset and idle
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_cyc", {31'h0, wb_cyc_o}, 32'h0);
      end
      check("rst_ack", {31'h0, node_ack_o}, 32'h0);
      check("rst_data", node_data_o, 32'h0);
      check("rst_nadr", node_adr_o, 32'h0);
      check("rst_stb", {31'h0, wb_stb_o}, 32'h0);
      check("rst_wbadr", wb_adr_o, 32'h0);
      check("rst_sel", {28'h0, wb_sel_o}, 32'hF);
      check("rst_we", {31'h0, wb_we_o}, 32'h0);

      // 2: near miss then hit
      do_req(32'h100, 1'b0, 32'hDEADBEEF, 32'h100, 1, -1, 1'b0);
      if (bus_log.size() == 1) check("miss_bus_adr", bus_log[0], 32'h100);
      else check("miss_bus_cnt", bus_log.size(), 32'd1);
      do_req(32'h100, 1'b0, 32'hDEADBEEF, 32'h100, 0, 2, 1'b0);

      // 3: far pointer, then an all-hit far pointer elsewhere
      do_req(32'h200, 1'b1, 32'h12345678, 32'h400, 2, -1, 1'b0);
      if (bus_log.size() == 2) begin
         check("far_bus0", bus_log[0], 32'h200);
         check("far_bus1", bus_log[1], 32'h400);
      end else check("far_bus_cnt", bus_log.size(), 32'd2);
      do_req(32'h208, 1'b1, 32'h55AA33CC, 32'h40C, 2, -1, 1'b0);
      do_req(32'h208, 1'b1, 32'h55AA33CC, 32'h40C, 0, 3, 1'b0);

      // 4: conflicting lines at index 0
      do_req(32'h100, 1'b0, 32'hDEADBEEF, 32'h100, 1, -1, 1'b0);
      do_req(32'h140, 1'b0, 32'h0BADF00D, 32'h140, 1, -1, 1'b0);
      do_req(32'h100, 1'b0, 32'hDEADBEEF, 32'h100, 1, -1, 1'b0);

      // 5: flush after a fill, then flush during the bus cycle
      do_req(32'h100, 1'b0, 32'hDEADBEEF, 32'h100, 0, 2, 1'b0);
      flush_idle();
      do_req(32'h100, 1'b0, 32'hDEADBEEF, 32'h100, 1, -1, 1'b0);
      flush_idle();
      do_req(32'h100, 1'b0, 32'hDEADBEEF, 32'h100, 1, -1, 1'b1);
      do_req(32'h100, 1'b0, 32'hDEADBEEF, 32'h100, 1, -1, 1'b0);
      do_req(32'h100, 1'b0, 32'hDEADBEEF, 32'h100, 0, 2, 1'b0);

      // 6a: bus error returns zero and leaves the line unfilled
      err_en  = 1'b1;
      err_adr = 32'h300;
      do_req(32'h300, 1'b0, 32'h0, 32'h300, 1, -1, 1'b0);
      err_en = 1'b0;
      do_req(32'h300, 1'b0, 32'hCAFEF00D, 32'h300, 1, -1, 1'b0);

      // 6b: reset in the middle of a bus cycle
      @(posedge clk);
      #1;
      node_req_i     = 1'b1;
      node_req_far_i = 1'b0;
      node_req_adr_i = 32'h500;
      n = 0;
      while (!wb_cyc_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_cyc_seen", {31'h0, wb_cyc_o}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_cyc", {31'h0, wb_cyc_o}, 32'h0);
      check("rst_mid_stb", {31'h0, wb_stb_o}, 32'h0);
      check("rst_mid_ack", {31'h0, node_ack_o}, 32'h0);
      $display("reset asserted mid-bus: cyc=%0b stb=%0b", wb_cyc_o, wb_stb_o);
      node_req_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      do_req(32'h500, 1'b0, 32'h600DCAFE, 32'h500, 1, -1, 1'b0);
      do_req(32'h100, 1'b0, 32'hDEADBEEF, 32'h100, 1, -1, 1'b0);

      check("sb_empty", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
